system_bus_ram: RTL
===================

# system_bus_ram

On-chip RAM target on the CPU's system bus. It accepts the single-master request stream (`system_bus_*`) issued by instruction fetch and, later, load/store, and returns read data over a fixed, parameterised latency pipeline. After reset it zero-fills itself before advertising ready, so fetch never sees uninitialised contents.

## Interface

- `ADDR_BITS`, 12: word-address width. Capacity is 2^ADDR_BITS 32-bit words.
- `READ_LATENCY`, 2: cycles from read acceptance to `read_data_valid`. Legal range 1..4.

- `clk`  in  1: sole clock. All state is updated on the rising edge.
- `reset`  in  1: asynchronous, active-high reset. One clock; reset is asynchronous and active-high.
- `system_bus_ready`  out  1: target can accept a request this cycle.
- `system_bus_addr`  in  32: byte address. Word index is `addr[ADDR_BITS+1:2]`. Bits [1:0] and bits above ADDR_BITS+1 are ignored, so the RAM aliases.
- `system_bus_write_data`  in  32: write data.
- `system_bus_byte_enable`  in  4: bit i enables byte lane i (bits 8i+7:8i) on writes. Ignored on reads.
- `system_bus_write_req`  in  1: write request.
- `system_bus_read_req`  in  1: read request.
- `system_bus_read_data`  out  32: read data. Meaningful only while valid.
- `system_bus_read_data_valid`  out  1: one-cycle pulse per accepted read.

## Operation

- FSM states are INIT and RUN. Reset forces INIT with the init counter at 0.
- INIT:
  - Each cycle writes 0 to word[counter] and increments the counter.
  - After word 2^ADDR_BITS-1 is written, the FSM moves to RUN.
  - `ready` = 0 throughout INIT.
- RUN:
  - `ready` = 1 constantly; the block never backpressures.
- Acceptance:
  - A request is accepted on an edge where `ready` & (`write_req` | `read_req`).
  - Requests while `ready` = 0 are ignored and leave no side effects.
- Write:
  - For each set `byte_enable` bit, that lane of the addressed word takes the `write_data` lane.
  - Other lanes are unchanged.
  - `byte_enable` = 0 is a legal no-op.
- Read:
  - The word index enters the latency pipeline.
  - The data of the addressed word, sampled at acceptance, appears READ_LATENCY cycles later.
- `write_req` and `read_req` together:
  - Protocol violation.
  - The write is performed, the read is dropped, and no valid pulse is produced.
- Reset mid-operation:
  - All in-flight reads are discarded; no valid pulse follows reset.
  - INIT restarts at word 0.
  - Memory contents are re-zeroed regardless of prior state.

## Timing

- Reset values:
  - `system_bus_ready` = 0
  - `system_bus_read_data_valid` = 0
  - `system_bus_read_data` = 0
  - FSM = INIT, counter = 0, valid pipeline all 0
- Init duration:
  - Counted from the first rising edge with `reset` low, `ready` rises after exactly 2^ADDR_BITS edges.
  - With defaults, `ready` is high in the cycle after the 4096th edge.
- Read latency:
  - A read accepted at edge N gives `read_data_valid` = 1 from edge N+READ_LATENCY-1 to edge N+READ_LATENCY, i.e. sampled by the master at edge N+READ_LATENCY.
  - The pulse lasts exactly one cycle.
- Throughput:
  - One request per cycle, in any mix of reads and writes.
  - Read responses return strictly in acceptance order with no gaps added.
- Read-after-write:
  - A write accepted at edge N is visible to a read accepted at edge N+1 or later.
  - Reads accepted at or before edge N return old data.
- `read_data` holds its last value when valid is low. The master must not depend on this.

## Test plan

- Reset release with defaults -> `ready` low for 4096 cycles, then high. A read of 0x0000_0ffc returns 0x0000_0000 with valid exactly 2 cycles after acceptance.
- Write 0xdeadbeef with be=4'b1111 to 0x10, then write 0x00005500 with be=4'b0010 to 0x10, then read 0x10 -> 0xdead55ef.
- Write 0x11111111..0x44444444 to 0x0/0x4/0x8/0xc, then 4 back-to-back reads -> 4 consecutive valid cycles, in order, starting 2 cycles after the first read. Repeat with READ_LATENCY=1 and 4.
- Write 0xcafef00d to 0x4010 with ADDR_BITS=12, then read 0x0010 -> 0xcafef00d (aliasing). A read issued while `ready`=0 during INIT -> no valid pulse, contents unchanged.
- Three reads in flight, assert `reset` asynchronously mid-cycle -> `ready` and valid drop immediately, no valid pulse afterwards. After the full re-init, a read of the previously written 0x10 returns 0.
- `write_req` and `read_req` both high to 0x20 with data 0x12345678, be=4'hf -> no valid pulse. A subsequent read of 0x20 returns 0x12345678.

Source files
------------

// File: rtl/system_bus_ram.sv
// system_bus_ram: on-chip RAM target for the CPU system bus.
// After reset the RAM zero-fills itself one word per cycle, and only then
// raises ready. Reads return through a fixed READ_LATENCY-stage pipeline.
// Writes have byte-lane enables. The RAM accepts one request per cycle and
// never backpressures once it is running.
module system_bus_ram #(
  parameter int ADDR_BITS    = 12,
  parameter int READ_LATENCY = 2   // legal range 1..4
) (
  input  logic        clk,
  input  logic        reset,
  output logic        system_bus_ready,
  input  logic [31:0] system_bus_addr,
  input  logic [31:0] system_bus_write_data,
  input  logic [3:0]  system_bus_byte_enable,
  input  logic        system_bus_write_req,
  input  logic        system_bus_read_req,
  output logic [31:0] system_bus_read_data,
  output logic        system_bus_read_data_valid
);

  localparam int DEPTH = 2 ** ADDR_BITS;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t                 state_q;
  logic [ADDR_BITS-1:0]   init_cnt_q;
  logic                   ready_q;

  logic [31:0]            mem_q [DEPTH];

  logic [READ_LATENCY-1:0] rd_valid_q;
  logic [31:0]             rd_data_q [READ_LATENCY];

  logic [ADDR_BITS-1:0]   word_idx;
  logic [31:0]            rd_word;
  logic                   accept_wr;
  logic                   accept_rd;
  logic                   unused_addr_bits;

  // The word index drops the byte offset and everything above the RAM size,
  // so the RAM aliases across the whole 32-bit address space.
  assign word_idx         = system_bus_addr[ADDR_BITS+1:2];
  assign unused_addr_bits = ^{system_bus_addr[31:ADDR_BITS+2], system_bus_addr[1:0]};

  // A write wins over a simultaneous read. In that case the read is dropped and
  // no response is produced.
  assign accept_wr = ready_q & system_bus_write_req;
  assign accept_rd = ready_q & system_bus_read_req & ~system_bus_write_req;

  assign rd_word = mem_q[word_idx];

  // Init/run FSM: sweeps the init counter across every word, then raises ready.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: sequential state uses non-blocking assignments only. A blocking
    // assignment here would let later statements see the new value in the same
    // edge and would break the register semantics.
    if (reset) begin
      state_q    <= ST_INIT;
      init_cnt_q <= '0;
      ready_q    <= 1'b0;
    end else begin
      case (state_q)
        ST_INIT: begin
          init_cnt_q <= init_cnt_q + 1'b1;
          if (init_cnt_q == '1) begin
            state_q <= ST_RUN;
            ready_q <= 1'b1;
          end
        end
        ST_RUN: begin
          ready_q <= 1'b1;
        end
        default: begin
          state_q <= ST_INIT;
          ready_q <= 1'b0;
        end
      endcase
    end
  end

  // Storage array: zero-fill during INIT, then byte-lane writes.
  always_ff @(posedge clk) begin
    // NOTE: the array has no reset branch on purpose. The INIT sweep clears it,
    // which keeps it mappable to plain RAM instead of thousands of resettable flops.
    if (state_q == ST_INIT) begin
      mem_q[init_cnt_q] <= '0;
    end else if (accept_wr) begin
      for (int i = 0; i < 4; i++) begin
        if (system_bus_byte_enable[i]) begin
          mem_q[word_idx][8*i +: 8] <= system_bus_write_data[8*i +: 8];
        end
      end
    end
  end

  // Read pipeline: data is captured at acceptance and then shifted toward the
  // output. A stage reloads only when valid data arrives, so the output holds
  // its last value between responses.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_valid_q <= '0;
      for (int i = 0; i < READ_LATENCY; i++) begin
        rd_data_q[i] <= '0;
      end
    end else begin
      rd_valid_q[0] <= accept_rd;
      if (accept_rd) begin
        rd_data_q[0] <= rd_word;
      end
      for (int i = 1; i < READ_LATENCY; i++) begin
        rd_valid_q[i] <= rd_valid_q[i-1];
        if (rd_valid_q[i-1]) begin
          rd_data_q[i] <= rd_data_q[i-1];
        end
      end
    end
  end

  assign system_bus_ready           = ready_q;
  assign system_bus_read_data_valid = rd_valid_q[READ_LATENCY-1];
  assign system_bus_read_data       = rd_data_q[READ_LATENCY-1];

endmodule
